mseq_ctrl: RTL and testbench
============================

# mseq_ctrl

Run controller for the 5-bit M-sequence generator (`mfun`). Each run loads a seed phase and a type word into the generator, then steps the phase register once per clock for a programmed number of 31-chip periods. At every period boundary it checks that the generator returned to its seed, so non-maximal type words are flagged. It replaces the free-running phase register in front of `mfun`/`dec` and gives the rest of the design start/stop/done control.

## Interface
Parameters:
- PHASE_INIT, 5'b10101, seed used after reset until a configuration is accepted
- TYPE_INIT, 5'b11101, type word used after reset until a configuration is accepted
- PERIOD, 31, chips per sequence period (2^5-1)

Ports:
- CLK_50MHZ  in  1  single system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready
- cfg_fase  in  5  seed phase
- cfg_type  in  5  type word for `mfun`
- cfg_periods  in  8  periods per run, 0 = continuous
- cfg_err  out  1  one-cycle pulse when an offered configuration is rejected
- start  in  1  run request, sampled in IDLE only
- stop  in  1  abort request, sampled in RUN only
- fase_new  in  5  next phase from `mfun`
- fase  out  5  phase register driving `mfun.fase`
- type_f  out  5  type register driving `mfun.type_f`
- chip_en  out  1  high while `mfun.sum` is a valid chip
- busy  out  1  high in LOAD and RUN
- chip_idx  out  5  chip position in the current period, 0..PERIOD-1
- period_cnt  out  8  completed periods in the current run
- period_end  out  1  one-cycle pulse on the last chip of each period
- done  out  1  one-cycle pulse when a run ends
- seq_err  out  1  sticky flag: phase did not return to the seed at a period end

## Operation
- Reset values: state IDLE, fase=PHASE_INIT, type_f=TYPE_INIT, shadow seed/type = PHASE_INIT/TYPE_INIT, shadow periods=1, cfg_ready=1, all other outputs 0.
- Shadow configuration registers: seed, type, periods.
- States:
  - IDLE:
    - cfg_ready=1.
    - A handshake with cfg_fase != 0 writes the shadows.
    - A handshake with cfg_fase == 0 leaves the shadows unchanged and pulses cfg_err the next cycle.
    - start=1 moves to LOAD.
  - LOAD (1 cycle):
    - fase <= shadow seed, type_f <= shadow type, chip_idx <= 0, period_cnt <= 0, seq_err <= 0.
    - Moves to RUN.
  - RUN: chip_en=1. Every cycle fase <= fase_new and chip_idx increments. When chip_idx == PERIOD-1:
    - period_end=1 and period_cnt increments (mod 256).
    - chip_idx <= 0 and fase <= shadow seed (forced resync).
    - seq_err <= 1 if fase_new != shadow seed.
    - If shadow periods != 0 and the incremented period_cnt == shadow periods, moves to DONE.
  - RUN, stop=1: moves to DONE next edge. Exception: a stop on a period-end cycle completes that period-end bookkeeping first.
  - DONE (1 cycle): done=1, chip_en=0. Moves to IDLE.
- cfg_ready=0 outside IDLE; offers there are neither accepted nor flagged.
- start outside IDLE is ignored. stop outside RUN is ignored.
- Simultaneous cfg handshake and start in IDLE: the new configuration is captured and used by the LOAD that follows.
- RST in any state returns every register to its reset value at that edge. No done pulse is generated.
- Continuous mode (periods=0): runs until stop; period_cnt wraps 255->0.

## Timing
- start sampled at edge k: LOAD during cycle k+1, first RUN cycle k+2 with fase = seed.
- chip_en covers exactly PERIOD*N cycles for a complete N-period run.
- done occurs the cycle after the last RUN cycle; IDLE the cycle after that. The earliest next start is accepted in that IDLE cycle.
- Latency from start to the first valid chip: 2 cycles.
- period_end, done and cfg_err are single-cycle pulses.
- seq_err updates on the edge ending a period_end cycle and holds until the next LOAD.

## Test plan
- Defaults, cfg_periods=2, start: chip_en high 62 cycles; period_end at chip_idx 30 in both periods; period_cnt 1 then 2; done 1 cycle after; seq_err=0; fase=5'b10101 on the first RUN cycle and after each boundary.
- cfg_type=5'b00000, cfg_fase=5'b00001, cfg_periods=1: seq_err=1 after the first period_end; done still pulses after 31 chips.
- cfg_fase=0 offered in IDLE: cfg_err pulse; the next run still starts from the prior seed. cfg offered during RUN: cfg_ready=0, shadows unchanged.
- Continuous mode, stop at chip_idx 10 of period 3: no period_end on that cycle, done next cycle, period_cnt=2. stop on a period-end cycle: period_cnt increments, then done.
- RST asserted mid-RUN: next cycle all outputs at reset values, state IDLE, no done pulse.
- cfg_valid and start in the same IDLE cycle (cfg_fase=5'b00011): the first RUN cycle shows fase=5'b00011.

Source files
------------

// File: rtl/mseq_ctrl.sv
// Run controller for the 5-bit M-sequence generator: loads seed/type, steps the phase
// once per clock for N periods and flags type words whose sequence does not return to the seed.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting; configuration offers accepted, start sampled
// S_LOAD | one cycle: copy shadow seed/type into the generator registers
// S_RUN  | stepping the phase; chips valid; stop sampled
// S_DONE | one cycle: done pulse, then back to S_IDLE

module mseq_ctrl #(
  parameter logic [4:0] PHASE_INIT = 5'b10101,
  parameter logic [4:0] TYPE_INIT  = 5'b11101,
  parameter int         PERIOD     = 31
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [4:0] cfg_fase,
  input  logic [4:0] cfg_type,
  input  logic [7:0] cfg_periods,
  output logic       cfg_err,
  input  logic       start,
  input  logic       stop,
  input  logic [4:0] fase_new,
  output logic [4:0] fase,
  output logic [4:0] type_f,
  output logic       chip_en,
  output logic       busy,
  output logic [4:0] chip_idx,
  output logic [7:0] period_cnt,
  output logic       period_end,
  output logic       done,
  output logic       seq_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(PERIOD - 1);

  state_t     r_state;
  state_t     w_state_nxt;

  logic [4:0] r_sh_seed;
  logic [4:0] r_sh_type;
  logic [7:0] r_sh_periods;

  logic [4:0] r_fase;
  logic [4:0] r_type_f;
  logic [4:0] r_chip_idx;
  logic [7:0] r_period_cnt;
  logic       r_seq_err;
  logic       r_cfg_err;

  logic       w_cfg_ready;
  logic       w_chip_en;
  logic       w_busy;
  logic       w_done;
  logic       w_last_chip;
  logic       w_cfg_hs;
  logic       w_cfg_ok;
  logic       w_cfg_bad;
  logic       w_run_complete;
  logic [7:0] w_period_inc;

  assign w_cfg_hs       = cfg_valid && w_cfg_ready;
  assign w_cfg_ok       = w_cfg_hs && (cfg_fase != 5'd0);
  assign w_cfg_bad      = w_cfg_hs && (cfg_fase == 5'd0);
  assign w_period_inc   = r_period_cnt + 8'd1;
  // A zero period count means continuous: only stop ends the run.
  assign w_run_complete = w_last_chip && (r_sh_periods != 8'd0) &&
                          (w_period_inc == r_sh_periods);

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN:  if (stop || w_run_complete) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cfg_ready = 1'b0;
    w_chip_en   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_last_chip = 1'b0;
    unique case (r_state)
      S_IDLE: w_cfg_ready = 1'b1;
      S_LOAD: w_busy = 1'b1;
      S_RUN: begin
        w_chip_en   = 1'b1;
        w_busy      = 1'b1;
        w_last_chip = (r_chip_idx == LAST_IDX);
      end
      S_DONE: w_done = 1'b1;
      default: w_cfg_ready = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_sh_seed    <= PHASE_INIT;
      r_sh_type    <= TYPE_INIT;
      r_sh_periods <= 8'd1;
    end else if (w_cfg_ok) begin
      r_sh_seed    <= cfg_fase;
      r_sh_type    <= cfg_type;
      r_sh_periods <= cfg_periods;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_bad;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_fase       <= PHASE_INIT;
      r_type_f     <= TYPE_INIT;
      r_chip_idx   <= 5'd0;
      r_period_cnt <= 8'd0;
      r_seq_err    <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_fase       <= r_sh_seed;
        r_type_f     <= r_sh_type;
        r_chip_idx   <= 5'd0;
        r_period_cnt <= 8'd0;
        r_seq_err    <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (w_last_chip) begin
          // Resync to the seed every period so one bad type word cannot drift later periods.
          r_fase       <= r_sh_seed;
          r_chip_idx   <= 5'd0;
          r_period_cnt <= w_period_inc;
          if (fase_new != r_sh_seed) begin
            r_seq_err <= 1'b1;
          end
        end else begin
          r_fase     <= fase_new;
          r_chip_idx <= r_chip_idx + 5'd1;
        end
      end
    end
  end

  assign cfg_ready  = w_cfg_ready;
  assign cfg_err    = r_cfg_err;
  assign fase       = r_fase;
  assign type_f     = r_type_f;
  assign chip_en    = w_chip_en;
  assign busy       = w_busy;
  assign chip_idx   = r_chip_idx;
  assign period_cnt = r_period_cnt;
  assign period_end = w_last_chip;
  assign done       = w_done;
  assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_mseq_ctrl.sv
// Scoreboard bench for mseq_ctrl: stimulus pushes expected chips/done/cfg_err events,
// a negedge monitor pops and compares them as the DUT presents them.

module tb_mseq_ctrl;

  localparam logic [4:0] P_INIT = 5'b10101;
  localparam logic [4:0] T_INIT = 5'b11101;
  localparam int         PER    = 31;

  logic       CLK_50MHZ = 1'b0;
  logic       RST = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [4:0] cfg_fase = 5'd0;
  logic [4:0] cfg_type = 5'd0;
  logic [7:0] cfg_periods = 8'd0;
  logic       cfg_err;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] fase_new;
  logic [4:0] fase;
  logic [4:0] type_f;
  logic       chip_en;
  logic       busy;
  logic [4:0] chip_idx;
  logic [7:0] period_cnt;
  logic       period_end;
  logic       done;
  logic       seq_err;

  mseq_ctrl #(.PHASE_INIT(P_INIT), .TYPE_INIT(T_INIT), .PERIOD(PER)) dut (
    .CLK_50MHZ(CLK_50MHZ), .RST(RST),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_fase(cfg_fase),
    .cfg_type(cfg_type), .cfg_periods(cfg_periods), .cfg_err(cfg_err),
    .start(start), .stop(stop), .fase_new(fase_new), .fase(fase), .type_f(type_f),
    .chip_en(chip_en), .busy(busy), .chip_idx(chip_idx), .period_cnt(period_cnt),
    .period_end(period_end), .done(done), .seq_err(seq_err)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  // Generator stand-in: shift left, feedback = parity of the type-selected taps.
  function automatic logic [4:0] gen_next(input logic [4:0] f, input logic [4:0] t);
    return {f[3:0], ^(f & t)};
  endfunction

  assign fase_new = gen_next(fase, type_f);

  typedef struct {
    int         cyc;
    logic [4:0] fase;
    logic [4:0] idx;
    logic [7:0] pcnt;
    logic       pend;
    logic       serr;
  } chip_t;

  typedef struct {
    int         cyc;
    logic [7:0] pcnt;
    logic       serr;
  } done_t;

  chip_t chip_q[$];
  done_t done_q[$];
  int    err_q[$];

  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;

  logic [4:0] m_seed = P_INIT;
  logic [4:0] m_type = T_INIT;
  logic [7:0] m_per  = 8'd1;

  always @(posedge CLK_50MHZ) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_total++;
    n_bad++;
    $display("FAIL %s at cyc %0d: unexpected event, got 1 expected 0", nm, cyc);
  endtask

  task automatic tick;
    @(posedge CLK_50MHZ);
    #1;
  endtask

  chip_t m_c;
  done_t m_d;
  int    m_e;

  always @(negedge CLK_50MHZ) begin
    if (!RST) begin
      if (chip_en) begin
        if (chip_q.size() == 0) flag("chip_extra");
        else begin
          m_c = chip_q.pop_front();
          chk("chip_cyc", cyc, m_c.cyc);
          chk("fase", fase, m_c.fase);
          chk("chip_idx", chip_idx, m_c.idx);
          chk("period_cnt", period_cnt, m_c.pcnt);
          chk("period_end", period_end, m_c.pend);
          chk("seq_err_run", seq_err, m_c.serr);
          chk("busy_run", busy, 1);
        end
      end else begin
        chk("period_end_quiet", period_end, 0);
      end
      if (done) begin
        if (done_q.size() == 0) flag("done_extra");
        else begin
          m_d = done_q.pop_front();
          chk("done_cyc", cyc, m_d.cyc);
          chk("done_pcnt", period_cnt, m_d.pcnt);
          chk("done_seq_err", seq_err, m_d.serr);
          chk("chips_left_at_done", chip_q.size(), 0);
        end
      end
      if (cfg_err) begin
        if (err_q.size() == 0) flag("cfg_err_extra");
        else begin
          m_e = err_q.pop_front();
          chk("cfg_err_cyc", cyc, m_e);
        end
      end
    end
  end

  task automatic model_cfg(input logic [4:0] f, input logic [4:0] t, input logic [7:0] p,
                           input int e);
    if (f != 5'd0) begin
      m_seed = f;
      m_type = t;
      m_per  = p;
    end else begin
      err_q.push_back(e);
    end
  endtask

  // Chip i of a run started at edge e is presented in cycle e+1+i.
  task automatic push_run(input int e, input int n_chips);
    logic [4:0] p;
    logic [4:0] f;
    bit         nonmax;
    chip_t      c;
    done_t      d;
    p = m_seed;
    for (int k = 0; k < PER; k++) p = gen_next(p, m_type);
    nonmax = (p != m_seed);
    f = m_seed;
    for (int i = 0; i < n_chips; i++) begin
      if (i % PER == 0) f = m_seed;
      c.cyc  = e + 1 + i;
      c.fase = f;
      c.idx  = 5'(i % PER);
      c.pcnt = 8'((i / PER) % 256);
      c.pend = ((i % PER) == PER - 1);
      c.serr = (i >= PER) && nonmax;
      chip_q.push_back(c);
      f = gen_next(f, m_type);
    end
    d.cyc  = e + 1 + n_chips;
    d.pcnt = 8'((n_chips / PER) % 256);
    d.serr = (n_chips >= PER) && nonmax;
    done_q.push_back(d);
  endtask

  task automatic check_reset;
    chk("rst_fase", fase, P_INIT);
    chk("rst_type_f", type_f, T_INIT);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_chip_en", chip_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_chip_idx", chip_idx, 0);
    chk("rst_period_cnt", period_cnt, 0);
    chk("rst_period_end", period_end, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_cfg_err", cfg_err, 0);
  endtask

  task automatic cfg(input logic [4:0] f, input logic [4:0] t, input logic [7:0] p);
    cfg_valid   = 1'b1;
    cfg_fase    = f;
    cfg_type    = t;
    cfg_periods = p;
    tick;
    cfg_valid = 1'b0;
    model_cfg(f, t, p, cyc);
  endtask

  task automatic idle(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      if (noisy) begin
        stop        = 1'($urandom_range(0, 1));
        cfg_valid   = ($urandom_range(0, 3) == 0);
        cfg_fase    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        cfg_type    = 5'($urandom);
        cfg_periods = 8'($urandom_range(0, 3));
      end
      tick;
      if (cfg_valid) model_cfg(cfg_fase, cfg_type, cfg_periods, cyc);
      stop      = 1'b0;
      cfg_valid = 1'b0;
    end
  endtask

  task automatic run(input bit with_cfg, input logic [4:0] cf, input logic [4:0] ct,
                     input logic [7:0] cp, input int stop_in, input int rst_at);
    int e;
    int n_chips;
    int stop_at;
    stop_at = stop_in;
    start = 1'b1;
    if (with_cfg) begin
      cfg_valid   = 1'b1;
      cfg_fase    = cf;
      cfg_type    = ct;
      cfg_periods = cp;
    end
    tick;
    e = cyc;
    start     = 1'b0;
    cfg_valid = 1'b0;
    if (with_cfg) model_cfg(cf, ct, cp, e);
    if (m_per == 8'd0 && stop_at < 0) stop_at = $urandom_range(0, 3 * PER);
    if (m_per != 8'd0 && stop_at >= PER * int'(m_per)) stop_at = -1;
    n_chips = (stop_at >= 0) ? stop_at + 1 : PER * int'(m_per);
    push_run(e, n_chips);
    for (int c = 0; c < n_chips + 3; c++) begin
      if (rst_at >= 0 && c == rst_at) begin
        RST = 1'b1;
        start = 1'b0;
        cfg_valid = 1'b0;
        chip_q.delete();
        done_q.delete();
        err_q.delete();
        tick;
        RST = 1'b0;
        m_seed = P_INIT;
        m_type = T_INIT;
        m_per  = 8'd1;
        check_reset;
        return;
      end
      if (stop_at >= 0 && c == stop_at + 1) stop = 1'b1;
      // Requests outside IDLE must be ignored: no cfg_err, no shadow change, no restart.
      if (c < n_chips) begin
        start       = 1'($urandom_range(0, 1));
        cfg_valid   = 1'($urandom_range(0, 1));
        cfg_fase    = 5'($urandom);
        cfg_type    = 5'($urandom);
        cfg_periods = 8'($urandom);
      end else begin
        start     = 1'b0;
        cfg_valid = 1'b0;
      end
      if (c == 3 && n_chips > 3) chk("cfg_ready_in_run", cfg_ready, 0);
      tick;
      stop = 1'b0;
    end
    start     = 1'b0;
    cfg_valid = 1'b0;
    chk("chip_q_drained", chip_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    tick;
    tick;
    RST = 1'b0;
    check_reset;
    idle(2, 1'b0);

    cfg(P_INIT, T_INIT, 8'd2);
    run(1'b0, 5'd0, 5'd0, 8'd0, -1, -1);

    cfg(5'b00001, 5'b00000, 8'd1);
    run(1'b0, 5'd0, 5'd0, 8'd0, -1, -1);

    cfg(5'b00000, 5'b11111, 8'd3);
    idle(2, 1'b0);
    run(1'b0, 5'd0, 5'd0, 8'd0, -1, -1);

    cfg(P_INIT, T_INIT, 8'd0);
    run(1'b0, 5'd0, 5'd0, 8'd0, 2 * PER + 10, -1);
    run(1'b0, 5'd0, 5'd0, 8'd0, PER + 30, -1);

    cfg(P_INIT, T_INIT, 8'd2);
    run(1'b0, 5'd0, 5'd0, 8'd0, 2 * PER - 1, -1);
    run(1'b0, 5'd0, 5'd0, 8'd0, -1, 20);
    idle(3, 1'b0);
    run(1'b0, 5'd0, 5'd0, 8'd0, -1, -1);

    run(1'b1, 5'b00011, T_INIT, 8'd1, -1, -1);

    cfg(P_INIT, T_INIT, 8'd0);
    run(1'b0, 5'd0, 5'd0, 8'd0, 257 * PER + 5, -1);

    for (int r = 0; r < 14; r++) begin
      idle($urandom_range(1, 4), 1'b1);
      run(1'($urandom_range(0, 1)),
          ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
          5'($urandom), 8'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 100)) : -1, -1);
    end

    idle(3, 1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
